// File: rtl/fpu_issue_sched_pkg.sv
// rtl/fpu_issue_sched_pkg.sv - opcodes, scheduler states and latency helper
package fpu_sched_pkg;

  localparam logic [3:0] OP_NONE = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_DIV  = 4'b1101;
  localparam logic [3:0] OP_SQRT = 4'b1110;
  localparam logic [3:0] OP_F2I  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  // Divide and square root occupy the datapath for the long latency.
  function automatic logic is_long_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_SQRT);
  endfunction

endpackage

// File: rtl/fpu_issue_sched_if.sv
// rtl/fpu_issue_sched_if.sv - requester, fpu and response signals of the issue scheduler
interface fpu_issue_sched_if #(
  parameter int NUM_REQ = 2,
  parameter int OPW     = 5,
  parameter int RES_W   = 32,
  parameter int TAG_W   = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) ();

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*4-1:0]     req_op;
  logic [NUM_REQ*OPW-1:0]   req_a;
  logic [NUM_REQ*OPW-1:0]   req_b;
  logic [NUM_REQ*TAG_W-1:0] req_tag;
  logic [3:0]               fpu_op;
  logic [OPW-1:0]           fpu_a;
  logic [OPW-1:0]           fpu_b;
  logic [RES_W-1:0]         fpu_result;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [TAG_W-1:0]         rsp_tag;
  logic [RES_W-1:0]         rsp_result;
  logic                     rsp_err;

  // Issue stage and execution unit side.
  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, fpu_result, rsp_ready,
    input  req_ready, fpu_op, fpu_a, fpu_b, rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_err
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, fpu_result, rsp_ready,
    output req_ready, fpu_op, fpu_a, fpu_b, rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_err
  );

endinterface

// File: rtl/fpu_issue_sched_rr_arbiter.sv
// rtl/fpu_issue_sched_rr_arbiter.sv - combinational round-robin one-hot arbiter
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt
);

  // Grant the first requester at or after the pointer, wrapping modulo N.
  always_comb begin
    logic w_found;
    int   w_idx;
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 0; i < N; i++) begin
      w_idx = (int'(i_ptr) + i) % N;
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_issue_sched.sv
// rtl/fpu_issue_sched.sv - shares one registered fpu among requesters, one op in flight
module fpu_issue_sched
  import fpu_sched_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int OPW       = 5,
  parameter int RES_W     = 32,
  parameter int TAG_W     = 4,
  parameter int LONG_LAT  = 8,
  parameter int SHORT_LAT = 1
) (
  input logic              clk,
  input logic              rst_n,
  fpu_issue_sched_if.slave bus
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(LONG_LAT + 1);

  sched_state_t       r_state;
  sched_state_t       w_state_nxt;
  logic [ID_W-1:0]    r_ptr;
  logic [3:0]         r_fpu_op;
  logic [OPW-1:0]     r_fpu_a;
  logic [OPW-1:0]     r_fpu_b;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_cnt_done;
  logic               r_rsp_valid;
  logic [ID_W-1:0]    r_rsp_id;
  logic [TAG_W-1:0]   r_rsp_tag;
  logic [RES_W-1:0]   r_rsp_result;
  logic               r_rsp_err;

  logic [NUM_REQ-1:0] w_arb_gnt;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_fire;
  logic [ID_W-1:0]    w_gidx;
  logic [ID_W-1:0]    w_ptr_nxt;
  logic [3:0]         w_sel_op;
  logic [OPW-1:0]     w_sel_a;
  logic [OPW-1:0]     w_sel_b;
  logic [TAG_W-1:0]   w_sel_tag;
  logic               w_sel_err;
  logic               w_exec_done;

  rr_arbiter #(.N(NUM_REQ), .PW(ID_W)) u_arb (
    .i_req (bus.req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt)
  );

  // Grants are only offered while idle and out of reset.
  assign w_gnt         = (r_state == IDLE && rst_n) ? w_arb_gnt : '0;
  assign w_fire        = |w_gnt;
  assign bus.req_ready = w_gnt;

  // Mux the granted requester's fields and work out its index.
  always_comb begin
    w_gidx    = '0;
    w_sel_op  = '0;
    w_sel_a   = '0;
    w_sel_b   = '0;
    w_sel_tag = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_gidx    = ID_W'(i);
        w_sel_op  = bus.req_op[i*4 +: 4];
        w_sel_a   = bus.req_a[i*OPW +: OPW];
        w_sel_b   = bus.req_b[i*OPW +: OPW];
        w_sel_tag = bus.req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  assign w_ptr_nxt   = (int'(w_gidx) == NUM_REQ - 1) ? '0 : w_gidx + 1'b1;
  assign w_sel_err   = (w_sel_op == OP_NONE) || (w_sel_op == OP_DIV && w_sel_b == '0);
  // The fpu registers its result, so capture one cycle after the hold count expires.
  assign w_exec_done = (r_cnt == '0) && r_cnt_done;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_fire) w_state_nxt = w_sel_err ? RESP : EXEC;
      EXEC:    if (w_exec_done) w_state_nxt = RESP;
      RESP:    if (bus.rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand latch, latency counter and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr        <= '0;
      r_fpu_op     <= '0;
      r_fpu_a      <= '0;
      r_fpu_b      <= '0;
      r_cnt        <= '0;
      r_cnt_done   <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_tag    <= '0;
      r_rsp_result <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_fire) begin
            r_ptr     <= w_ptr_nxt;
            r_rsp_id  <= w_gidx;
            r_rsp_tag <= w_sel_tag;
            if (w_sel_err) begin
              r_rsp_err    <= 1'b1;
              r_rsp_result <= '0;
              r_rsp_valid  <= 1'b1;
            end else begin
              r_fpu_op   <= w_sel_op;
              r_fpu_a    <= w_sel_a;
              r_fpu_b    <= w_sel_b;
              r_cnt      <= is_long_op(w_sel_op) ? CNT_W'(LONG_LAT - 1) : CNT_W'(SHORT_LAT - 1);
              r_cnt_done <= 1'b0;
            end
          end
        end
        EXEC: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (!r_cnt_done) begin
            r_cnt_done <= 1'b1;
          end else begin
            r_rsp_result <= bus.fpu_result;
            r_rsp_err    <= 1'b0;
            r_fpu_op     <= '0;
            r_rsp_valid  <= 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.fpu_op     = r_fpu_op;
  assign bus.fpu_a      = r_fpu_a;
  assign bus.fpu_b      = r_fpu_b;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_tag    = r_rsp_tag;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_err    = r_rsp_err;

endmodule
